// File: rtl/opb_register_bank_if.sv
// rtl/opb_register_bank_if.sv - OPB slave-side bus bundle for the register bank
interface opb_register_bank_if #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32
);
    logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
    logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
    logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
    logic                      OPB_RNW;
    logic                      OPB_select;
    logic                      OPB_seqAddr;
    logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
    logic                      Sl_xferAck;
    logic                      Sl_errAck;
    logic                      Sl_retry;
    logic                      Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank.sv
// rtl/opb_register_bank.sv - bank of 32-bit software/fabric registers on an OPB slave port
module opb_register_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_02FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter logic [63:0] C_RO_MASK    = 64'h0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    opb_register_bank_if.slave          opb,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    input  logic [32*C_NUM_REGS-1:0]    user_data_in,
    output logic [C_NUM_REGS-1:0]       user_wr_strobe
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_HOLD
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic                            w_accept;

    logic [C_NUM_REGS-1:0][31:0]     r_regs;
    logic [C_NUM_REGS-1:0][31:0]     r_ud_in;
    logic [31:0]                     r_rdata;
    logic                            r_ack;
    logic                            r_err;
    logic [C_NUM_REGS-1:0]           r_strobe;

    // Bus is MSB-first ([0:31]); plain assignment turns bit k into bit 31-k.
    logic [C_OPB_AWIDTH-1:0]         w_addr;
    logic [C_OPB_DWIDTH-1:0]         w_wdata;
    logic [C_OPB_DWIDTH/8-1:0]       w_be;
    logic [31:0]                     w_offset;
    logic [29:0]                     w_idx;
    logic                            w_hit;
    logic                            w_idx_ok;
    logic                            w_tgt_ro;
    logic                            w_wr_ok;
    logic [31:0]                     w_rd_word;
    logic                            w_unused_ok;

    assign w_addr   = opb.OPB_ABus;
    assign w_wdata  = opb.OPB_DBus;
    assign w_be     = opb.OPB_BE;
    assign w_offset = w_addr - C_BASEADDR;
    assign w_idx    = w_offset[31:2];
    assign w_hit    = opb.OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_idx_ok = (w_idx < 30'(C_NUM_REGS));
    assign w_wr_ok  = w_accept && !opb.OPB_RNW && w_idx_ok && !w_tgt_ro;

    // Indices past C_NUM_REGS match no entry, so they read as 0 and are never read-only.
    always_comb begin
        w_rd_word = '0;
        w_tgt_ro  = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_idx == 30'(i)) begin
                w_tgt_ro  = C_RO_MASK[i];
                w_rd_word = C_RO_MASK[i] ? r_ud_in[i] : r_regs[i];
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_next   = S_ACK;
                    w_accept = 1'b1;
                end
            end
            S_ACK:   w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        r_ud_in <= user_data_in;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= C_RO_MASK[i] ? 32'h0 : C_RESET_VAL;
            end
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_ok && (w_idx == 30'(i)) && w_be[b]) begin
                        r_regs[i][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read data is held only for the ACK cycle so the OR-combined bus sees 0 otherwise.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_strobe <= '0;
        end else begin
            r_ack   <= w_accept;
            r_err   <= w_accept && !opb.OPB_RNW && w_idx_ok && w_tgt_ro;
            r_rdata <= (w_accept && opb.OPB_RNW) ? w_rd_word : 32'h0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_strobe[i] <= w_wr_ok && (w_idx == 30'(i));
            end
        end
    end

    assign opb.Sl_DBus     = r_rdata;
    assign opb.Sl_xferAck  = r_ack;
    assign opb.Sl_errAck   = r_err;
    assign opb.Sl_retry    = 1'b0;
    assign opb.Sl_toutSup  = 1'b0;
    assign user_data_out   = r_regs;
    assign user_wr_strobe  = r_strobe;

    assign w_unused_ok = &{1'b0, opb.OPB_seqAddr, w_offset[1:0], 1'(C_FAMILY != "")};
endmodule

// File: tb/tb_opb_register_bank.sv
// tb/tb_opb_register_bank.sv - directed self-checking bench for opb_register_bank
module tb_opb_register_bank;
    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0100_0200;
    localparam logic [31:0] RV   = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    opb_register_bank_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) opb ();
    logic [32*N-1:0] udo;
    logic [32*N-1:0] udi;
    logic [N-1:0]    stb;

    opb_register_bank #(
        .C_BASEADDR(BASE), .C_HIGHADDR(32'h0100_02FF), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_NUM_REGS(N), .C_RO_MASK(64'h20), .C_RESET_VAL(RV), .C_FAMILY("virtex5")
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(opb.slave),
        .user_data_out(udo), .user_data_in(udi), .user_wr_strobe(stb)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]     x_rd, x_db_after;
    logic            x_ack, x_err, x_ack_after;
    logic [N-1:0]    x_stb, x_stb_after;
    logic [32*N-1:0] x_udo;

    task automatic bus_idle();
        opb.OPB_select  = 1'b0;
        opb.OPB_RNW     = 1'b1;
        opb.OPB_ABus    = '0;
        opb.OPB_BE      = '0;
        opb.OPB_DBus    = '0;
        opb.OPB_seqAddr = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        opb.OPB_ABus = addr; opb.OPB_RNW = rnw; opb.OPB_BE = be; opb.OPB_DBus = wd;
        opb.OPB_select = 1'b1;
        @(posedge clk); #1;
        x_rd = opb.Sl_DBus; x_ack = opb.Sl_xferAck; x_err = opb.Sl_errAck; x_stb = stb; x_udo = udo;
        @(negedge clk);
        bus_idle();
        @(posedge clk); #1;
        x_stb_after = stb; x_ack_after = opb.Sl_xferAck; x_db_after = opb.Sl_DBus;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [32*N-1:0] exp_udo;
        logic [31:0]     exp_rd;
        udi = '0;
        udi[31:0]    = 32'h1111_1111;
        udi[5*32 +: 32] = 32'hCAFE_0005;
        rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_udo[i*32 +: 32] = (i == 5) ? 32'h0 : RV;
        checks++;
        if (udo !== exp_udo) begin errors++; $display("FAIL reset_udo got %h want %h", udo, exp_udo); end
        checks++;
        if ({opb.Sl_xferAck, opb.Sl_errAck, opb.Sl_retry, opb.Sl_toutSup, stb} !== '0 || opb.Sl_DBus !== 32'h0) begin
            errors++; $display("FAIL reset_outs ack %b err %b dbus %h stb %b want all 0", opb.Sl_xferAck, opb.Sl_errAck, opb.Sl_DBus, stb);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            xfer(BASE + 32'(4*i), 1'b1, 4'h0, 32'h0);
            exp_rd = (i == 5) ? 32'hCAFE_0005 : RV;
            checks++;
            if (x_ack !== 1'b1 || x_err !== 1'b0 || x_rd !== exp_rd) begin
                errors++; $display("FAIL reset_read%0d ack %b err %b data %h want ack 1 err 0 data %h", i, x_ack, x_err, x_rd, exp_rd);
            end
            checks++;
            if (x_ack_after !== 1'b0 || x_db_after !== 32'h0) begin
                errors++; $display("FAIL reset_read%0d_after ack %b dbus %h want 0 0", i, x_ack_after, x_db_after);
            end
        end
    endtask

    task automatic test_write_be();
        xfer(BASE + 32'd8, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        checks++;
        if (x_ack !== 1'b1 || x_err !== 1'b0 || x_stb !== 8'b0000_0100 || x_stb_after !== 8'h00) begin
            errors++; $display("FAIL wr_full ack %b err %b stb %b stb_after %b want 1 0 00000100 00000000", x_ack, x_err, x_stb, x_stb_after);
        end
        checks++;
        if (x_udo[2*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_full_val got %h want deadbeef", x_udo[2*32 +: 32]); end
        xfer(BASE + 32'd8, 1'b0, 4'b0100, 32'h00AA_0000);
        checks++;
        if (x_udo[2*32 +: 32] !== 32'hDEAA_BEEF || x_stb !== 8'b0000_0100 || x_stb_after !== 8'h00) begin
            errors++; $display("FAIL wr_be val %h stb %b after %b want deaabeef 00000100 00000000", x_udo[2*32 +: 32], x_stb, x_stb_after);
        end
        xfer(BASE + 32'd28, 1'b0, 4'b0001, 32'h0000_00CC);
        checks++;
        if (udo[7*32 +: 32] !== 32'hA5A5_00CC) begin errors++; $display("FAIL wr_be_low got %h want a5a500cc", udo[7*32 +: 32]); end
        xfer(BASE + 32'd8, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_rd !== 32'hDEAA_BEEF || x_ack !== 1'b1) begin errors++; $display("FAIL wr_readback got %h ack %b want deaabeef 1", x_rd, x_ack); end
    endtask

    task automatic test_readonly();
        udi[5*32 +: 32] = 32'h1234_5678;
        @(posedge clk); #1;
        xfer(BASE + 32'd20, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_rd !== 32'h1234_5678 || x_ack !== 1'b1 || x_err !== 1'b0) begin
            errors++; $display("FAIL ro_read data %h ack %b err %b want 12345678 1 0", x_rd, x_ack, x_err);
        end
        xfer(BASE + 32'd20, 1'b0, 4'b1111, 32'hFFFF_FFFF);
        checks++;
        if (x_ack !== 1'b1 || x_err !== 1'b1 || x_stb !== 8'h00 || x_udo[5*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL ro_write ack %b err %b stb %b udo5 %h want 1 1 00000000 0", x_ack, x_err, x_stb, x_udo[5*32 +: 32]);
        end
        xfer(BASE + 32'd20, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_rd !== 32'h1234_5678) begin errors++; $display("FAIL ro_reread got %h want 12345678", x_rd); end
    endtask

    task automatic test_out_of_range();
        logic [32*N-1:0] exp_udo;
        int acks;
        for (int i = 0; i < N; i++) exp_udo[i*32 +: 32] = RV;
        exp_udo[5*32 +: 32] = 32'h0;
        exp_udo[2*32 +: 32] = 32'hDEAA_BEEF;
        exp_udo[7*32 +: 32] = 32'hA5A5_00CC;
        xfer(BASE + 32'd32, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_rd !== 32'h0 || x_ack !== 1'b1 || x_err !== 1'b0) begin
            errors++; $display("FAIL oor_read data %h ack %b err %b want 0 1 0", x_rd, x_ack, x_err);
        end
        xfer(BASE + 32'd32, 1'b0, 4'b1111, 32'hFFFF_FFFF);
        checks++;
        if (x_ack !== 1'b1 || x_err !== 1'b0 || x_stb !== 8'h00 || udo !== exp_udo) begin
            errors++; $display("FAIL oor_write ack %b err %b stb %b udo %h want 1 0 0 %h", x_ack, x_err, x_stb, udo, exp_udo);
        end
        xfer(BASE + 32'd14, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_rd !== RV || x_ack !== 1'b1) begin errors++; $display("FAIL low_bits_read got %h ack %b want %h 1", x_rd, x_ack, RV); end
        acks = 0;
        @(negedge clk);
        opb.OPB_ABus = BASE + 32'h100; opb.OPB_RNW = 1'b1; opb.OPB_select = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (opb.Sl_xferAck) acks++;
            if (e == 2) opb.OPB_ABus = BASE - 32'd4;
        end
        @(negedge clk);
        bus_idle();
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL outside_window acks %0d want 0", acks); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  mask;
        logic [31:0] first_rd;
        int          leaks;
        mask = '0; leaks = 0; first_rd = '0;
        @(negedge clk);
        opb.OPB_ABus = BASE + 32'd8; opb.OPB_RNW = 1'b1; opb.OPB_select = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            mask[e] = opb.Sl_xferAck;
            if (e == 0) first_rd = opb.Sl_DBus;
            if (!opb.Sl_xferAck && opb.Sl_DBus !== 32'h0) leaks++;
        end
        @(negedge clk);
        bus_idle();
        checks++;
        if (mask !== 6'b001001) begin errors++; $display("FAIL b2b_ack_cycles got %b want 001001", mask); end
        checks++;
        if (first_rd !== 32'hDEAA_BEEF || leaks !== 0) begin
            errors++; $display("FAIL b2b_data got %h leaks %0d want deaabeef 0", first_rd, leaks);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_ack();
        @(negedge clk);
        opb.OPB_ABus = BASE + 32'd4; opb.OPB_RNW = 1'b0; opb.OPB_BE = 4'b1111;
        opb.OPB_DBus = 32'h0F0F_0F0F; opb.OPB_select = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stb !== 8'b0000_0010 || opb.Sl_xferAck !== 1'b1) begin
            errors++; $display("FAIL rst_ack_cycle stb %b ack %b want 00000010 1", stb, opb.Sl_xferAck);
        end
        @(negedge clk);
        rst = 1'b1;
        bus_idle();
        @(posedge clk); #1;
        checks++;
        if (stb !== 8'h00 || opb.Sl_xferAck !== 1'b0 || udo[1*32 +: 32] !== RV || udo[2*32 +: 32] !== RV) begin
            errors++; $display("FAIL rst_in_ack stb %b ack %b r1 %h r2 %h want 0 0 %h %h", stb, opb.Sl_xferAck, udo[1*32 +: 32], udo[2*32 +: 32], RV, RV);
        end
        @(negedge clk);
        rst = 1'b0;
        xfer(BASE + 32'd4, 1'b1, 4'h0, 32'h0);
        checks++;
        if (x_ack !== 1'b1 || x_rd !== RV) begin errors++; $display("FAIL rst_recover ack %b data %h want 1 %h", x_ack, x_rd, RV); end
    endtask

    initial begin
        test_reset();
        test_write_be();
        test_readonly();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
